// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_pkg
//  Description : Shared constants for the pipelined barrel shifter. Holds the
//                operation-select width and the mode encodings. Codes
//                3'b101..3'b111 are passthrough.
//  Revision    : 1.0 - initial release
// ============================================================================
package barrel_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SLL = 3'b000;  // logical left, zero fill
    localparam logic [MODE_W-1:0] MODE_SRL = 3'b001;  // logical right, zero fill
    localparam logic [MODE_W-1:0] MODE_SRA = 3'b010;  // arithmetic right, sign fill
    localparam logic [MODE_W-1:0] MODE_ROL = 3'b011;  // rotate left
    localparam logic [MODE_W-1:0] MODE_ROR = 3'b100;  // rotate right

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
//  Module      : shift_level
//  Description : One combinational mux level of the barrel shifter. When
//                enabled, it shifts or rotates the operand by the constant
//                distance DIST in the direction selected by the mode.
//                Passthrough codes and a cleared enable return the operand
//                unchanged.
//  Ports       : i_data  - operand in
//                i_en    - this level's shift-amount bit
//                i_mode  - operation select
//                o_data  - operand out
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_mode)
                MODE_SLL: o_data = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                MODE_SRL: o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
                MODE_SRA: o_data = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
                MODE_ROL: o_data = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
                MODE_ROR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
                default:  o_data = i_data;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_barrel_shifter
//  Description : WIDTH-bit shifter/rotator built from SHW power-of-two mux
//                levels. A pipeline register follows every STAGES_PER_REG
//                levels, and the last level is always registered. The
//                latency is LAT = ceil(SHW / STAGES_PER_REG). All slots
//                advance together unless the output is stalled.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input handshake
//                in_data/amnt/mode/tag - operation
//                out_valid/out_ready - output handshake
//                out_data/out_tag    - result and its tag
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SHW            = $clog2(WIDTH),
    parameter int STAGES_PER_REG = 1,
    parameter int TAG_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SHW-1:0]    in_amnt,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LAT = (SHW + STAGES_PER_REG - 1) / STAGES_PER_REG;

    // Pipeline slots. Slot LAT-1 drives the outputs.
    logic [LAT-1:0][WIDTH-1:0]  data_d,  data_q;
    logic [LAT-1:0][SHW-1:0]    amnt_d,  amnt_q;
    logic [LAT-1:0][MODE_W-1:0] mode_d,  mode_q;
    logic [LAT-1:0][TAG_W-1:0]  tag_d,   tag_q;
    logic [LAT-1:0]             valid_d, valid_q;

    // Inputs seen by each stage's group of levels, and that group's result.
    logic [LAT-1:0][WIDTH-1:0]  w_stg_data;
    logic [LAT-1:0][SHW-1:0]    w_stg_amnt;
    logic [LAT-1:0][MODE_W-1:0] w_stg_mode;
    logic [LAT-1:0][TAG_W-1:0]  w_stg_tag;
    logic [LAT-1:0]             w_stg_valid;
    logic [LAT-1:0][WIDTH-1:0]  w_stg_res;

    logic [SHW-1:0][WIDTH-1:0]  w_lvl_out;
    logic                       w_adv;

    genvar gs, gk;

    generate
        for (gs = 0; gs < LAT; gs++) begin : g_stage
            localparam int LAST = (((gs + 1) * STAGES_PER_REG < SHW) ?
                                   (gs + 1) * STAGES_PER_REG : SHW) - 1;
            if (gs == 0) begin : g_src_port
                assign w_stg_data[gs]  = in_data;
                assign w_stg_amnt[gs]  = in_amnt;
                assign w_stg_mode[gs]  = in_mode;
                assign w_stg_tag[gs]   = in_tag;
                assign w_stg_valid[gs] = in_valid;
            end else begin : g_src_slot
                assign w_stg_data[gs]  = data_q[gs-1];
                assign w_stg_amnt[gs]  = amnt_q[gs-1];
                assign w_stg_mode[gs]  = mode_q[gs-1];
                assign w_stg_tag[gs]   = tag_q[gs-1];
                assign w_stg_valid[gs] = valid_q[gs-1];
            end
            assign w_stg_res[gs] = w_lvl_out[LAST];
        end

        for (gk = 0; gk < SHW; gk++) begin : g_level
            localparam int S = gk / STAGES_PER_REG;
            logic [WIDTH-1:0] w_lvl_in;
            // The first level of a stage starts from the stage input. Later
            // levels chain from the level before them.
            if (gk % STAGES_PER_REG == 0) begin : g_first
                assign w_lvl_in = w_stg_data[S];
            end else begin : g_chain
                assign w_lvl_in = w_lvl_out[gk-1];
            end
            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << gk)
            ) u_level (
                .i_data (w_lvl_in),
                .i_en   (w_stg_amnt[S][gk]),
                .i_mode (w_stg_mode[S]),
                .o_data (w_lvl_out[gk])
            );
        end
    endgenerate

    // A result that the consumer is refusing freezes the whole pipe, so
    // nothing can be overwritten and no bubble is squeezed out.
    assign w_adv = !(valid_q[LAT-1] && !out_ready);

    always_comb begin
        data_d  = data_q;
        amnt_d  = amnt_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (w_adv) begin
            for (int s = 0; s < LAT; s++) begin
                data_d[s]  = w_stg_res[s];
                amnt_d[s]  = w_stg_amnt[s];
                mode_d[s]  = w_stg_mode[s];
                tag_d[s]   = w_stg_tag[s];
                valid_d[s] = w_stg_valid[s];
                // Amount bits already consumed are dropped, so each slot
                // carries only the distance that still remains.
                for (int b = 0; b < SHW; b++) begin
                    if (b < (s + 1) * STAGES_PER_REG) begin
                        amnt_d[s][b] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            data_q[LAT-1]   <= '0;
            tag_q[LAT-1]    <= '0;
        end else begin
            data_q  <= data_d;
            amnt_q  <= amnt_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    // The last slot's amount and mode have no consumer. They are kept only
    // so that every slot has the same shape.
    logic w_unused_ok;
    assign w_unused_ok = ^{amnt_q[LAT-1], mode_q[LAT-1]};

    assign in_ready  = w_adv;
    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_barrel_shifter
//  Description : Self-checking bench for three builds of the shifter:
//                WIDTH=32/SPR=1, WIDTH=8/SPR=2 and WIDTH=64/SPR=3. Each
//                accepted operation is pushed to that build's scoreboard
//                with its acceptance cycle. A monitor pops entries and
//                checks the data, the tag and the latency; the expected
//                latency is extended by one cycle for each stall cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    import barrel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] din  [3];
    logic [5:0]  amt  [3];
    logic [2:0]  md   [3];
    logic [3:0]  tg   [3];
    logic        iv   [3];
    logic        ordy [3];

    logic        ov0, ov1, ov2, ir0, ir1, ir2;
    logic [31:0] od0;
    logic [7:0]  od1;
    logic [63:0] od2;
    logic [3:0]  ot0, ot1, ot2;

    logic        v_ov [3];
    logic        v_ir [3];
    logic [63:0] v_od [3];
    logic [3:0]  v_ot [3];

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES_PER_REG(1), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .in_data(din[0][31:0]), .in_amnt(amt[0][4:0]), .in_mode(md[0]), .in_tag(tg[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .out_tag(ot0));

    pipelined_barrel_shifter #(.WIDTH(8), .STAGES_PER_REG(2), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .in_data(din[1][7:0]), .in_amnt(amt[1][2:0]), .in_mode(md[1]), .in_tag(tg[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .out_tag(ot1));

    pipelined_barrel_shifter #(.WIDTH(64), .STAGES_PER_REG(3), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .in_data(din[2]), .in_amnt(amt[2]), .in_mode(md[2]), .in_tag(tg[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2), .out_tag(ot2));

    always_comb begin
        v_ov[0] = ov0; v_ov[1] = ov1; v_ov[2] = ov2;
        v_ir[0] = ir0; v_ir[1] = ir1; v_ir[2] = ir2;
        v_od[0] = {32'h0, od0}; v_od[1] = {56'h0, od1}; v_od[2] = od2;
        v_ot[0] = ot0; v_ot[1] = ot1; v_ot[2] = ot2;
    end

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        int          acc;
        int          hold;
    } exp_t;

    exp_t        sbq [3][$];
    int          cyc = 0;
    int          n_hold   [3];
    bit          was_hold [3];
    logic [63:0] last_d   [3];
    logic [3:0]  last_t   [3];
    int          n_vec = 0;
    int          n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int id);
        case (id)
            0:       return 32;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    function automatic int lat_of(input int id);
        case (id)
            0:       return 5;
            default: return 2;
        endcase
    endfunction

    // Bit-by-bit reference model of every mode.
    function automatic logic [63:0] ref_model(input logic [63:0] d, input int w,
                                              input int a, input logic [2:0] m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'b000:  r[i] = (i >= a) ? d[i-a] : 1'b0;
                3'b001:  r[i] = (i + a < w) ? d[i+a] : 1'b0;
                3'b010:  r[i] = (i + a < w) ? d[i+a] : d[w-1];
                3'b011:  r[i] = d[(i - a + w) % w];
                3'b100:  r[i] = d[(i + a) % w];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_data(input int w);
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        if (w < 64) d = d & ((64'h1 << w) - 64'h1);
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, want);
        end
    endtask

    task automatic mon(input int id);
        exp_t  e;
        string p;
        p = $sformatf("dut%0d", id);
        if (rst) begin
            sbq[id].delete();
            was_hold[id] = 1'b0;
            return;
        end
        check({p, "_in_ready"}, 64'(v_ir[id]), 64'(!(v_ov[id] && !ordy[id])));
        if (was_hold[id]) begin
            check({p, "_stall_data"}, v_od[id], last_d[id]);
            check({p, "_stall_tag"}, 64'(v_ot[id]), 64'(last_t[id]));
        end
        if (v_ov[id]) begin
            if (sbq[id].size() == 0) begin
                check({p, "_spurious_valid"}, 64'(v_ov[id]), 64'(0));
            end else if (ordy[id]) begin
                e = sbq[id].pop_front();
                check({p, "_data"}, v_od[id], e.data);
                check({p, "_tag"}, 64'(v_ot[id]), 64'(e.tag));
                check({p, "_latency"}, 64'(cyc),
                      64'(e.acc + lat_of(id) + n_hold[id] - e.hold));
            end
        end
        was_hold[id] = v_ov[id] && !ordy[id];
        if (was_hold[id]) begin
            n_hold[id]++;
            last_d[id] = v_od[id];
            last_t[id] = v_ot[id];
        end
    endtask

    always @(negedge clk) begin
        #1;
        for (int id = 0; id < 3; id++) mon(id);
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input int id, input logic [63:0] d, input int a,
                        input logic [2:0] m, input logic [3:0] t, input logic [63:0] want);
        exp_t e;
        int   guard;
        bit   ok;
        din[id] = d; amt[id] = 6'(a); md[id] = m; tg[id] = t; iv[id] = 1'b1;
        guard = 0;
        ok    = 1'b0;
        while (!ok && guard < 64) begin
            #1;
            if (v_ir[id] && !rst) ok = 1'b1;
            else begin
                guard++;
                @(negedge clk);
            end
        end
        if (ok) begin
            e.data = want; e.tag = t; e.acc = cyc; e.hold = n_hold[id];
            sbq[id].push_back(e);
        end else begin
            check($sformatf("dut%0d_accept_timeout", id), 64'(guard), 64'(0));
        end
        @(negedge clk);
        iv[id] = 1'b0;
    endtask

    task automatic send_ref(input int id, input logic [63:0] d, input int a,
                            input logic [2:0] m, input logic [3:0] t);
        send(id, d, a, m, t, ref_model(d, w_of(id), a, m));
    endtask

    task automatic drain(input int id);
        int g;
        g = 0;
        while (sbq[id].size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq[id].size() != 0)
            check($sformatf("dut%0d_drain_timeout", id), 64'(sbq[id].size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; amt[i] = '0; md[i] = '0; tg[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_reset_valid", i), 64'(v_ov[i]), 64'(0));
            check($sformatf("dut%0d_reset_data", i), v_od[i], 64'(0));
            check($sformatf("dut%0d_reset_tag", i), 64'(v_ot[i]), 64'(0));
        end
        @(negedge clk);

        // Basic modes with results from the worked examples.
        send(0, 64'hD6975971, 4, MODE_SLL, 4'd1, 64'h69759710);
        send(0, 64'hD6975971, 4, MODE_SRL, 4'd2, 64'h0D697597);
        send(0, 64'hD6975971, 4, MODE_SRA, 4'd3, 64'hFD697597);
        send(0, 64'hD6975971, 4, MODE_ROL, 4'd4, 64'h6975971D);
        send(0, 64'hD6975971, 8, MODE_ROR, 4'd5, 64'h71D69759);

        // Edge amounts and passthrough codes.
        for (int m = 0; m < 5; m++)
            send(0, 64'hD6975971, 0, 3'(m), 4'(m), 64'hD6975971);
        send(0, 64'h00000001, 31, MODE_SLL, 4'd6, 64'h80000000);
        send(0, 64'h80000000, 31, MODE_SRA, 4'd7, 64'hFFFFFFFF);
        send(0, 64'hD6975971, 5, 3'b111, 4'd8, 64'hD6975971);
        send(0, 64'h12345678, 3, 3'b101, 4'd9, 64'h12345678);
        drain(0);

        // Back-to-back: ten operations on consecutive cycles.
        for (int i = 0; i < 10; i++)
            send_ref(0, rand_data(32), $urandom_range(0, 31), 3'($urandom_range(0, 7)), 4'(i));
        drain(0);

        // Stall for three cycles while a result is at the output. Operation 6
        // is presented during the stall and must wait.
        for (int i = 0; i < 5; i++)
            send_ref(0, rand_data(32), $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(i));
        fork
            begin
                ordy[0] = 1'b0;
                repeat (3) begin
                    #1;
                    check("dut0_stall_in_ready", 64'(ir0), 64'(0));
                    @(negedge clk);
                end
                ordy[0] = 1'b1;
            end
            send_ref(0, 64'hCAFEF00D, 12, MODE_ROR, 4'd5);
        join
        send_ref(0, 64'h0F0F0F0F, 7, MODE_SLL, 4'd6);
        send_ref(0, 64'hF0000000, 9, MODE_SRA, 4'd7);
        drain(0);

        // Reset flush: two operations are in flight, and a third is
        // presented during the reset cycle.
        send_ref(0, 64'hAAAA5555, 1, MODE_ROL, 4'd1);
        send_ref(0, 64'h5555AAAA, 2, MODE_ROR, 4'd2);
        din[0] = 64'h11111111; amt[0] = 6'd3; md[0] = MODE_SLL; tg[0] = 4'd3; iv[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        iv[0] = 1'b0;
        #1;
        check("dut0_flush_valid", 64'(ov0), 64'(0));
        check("dut0_flush_data", 64'(od0), 64'(0));
        check("dut0_flush_tag", 64'(ot0), 64'(0));
        repeat (8) begin
            @(negedge clk);
            #1;
            check("dut0_flush_no_stale", 64'(ov0), 64'(0));
        end
        @(negedge clk);

        // Random operations with random backpressure.
        fork
            begin
                repeat (60) begin
                    ordy[0] = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                ordy[0] = 1'b1;
            end
            for (int i = 0; i < 20; i++)
                send_ref(0, rand_data(32), $urandom_range(0, 31), 3'($urandom_range(0, 7)), 4'(i));
        join
        drain(0);

        // Parameter sweep: WIDTH=8/SPR=2 and WIDTH=64/SPR=3.
        send_ref(1, 64'h80, 7, MODE_SRA, 4'd1);
        send_ref(1, 64'h01, 7, MODE_SLL, 4'd2);
        for (int i = 0; i < 20; i++) begin
            send_ref(1, rand_data(8), $urandom_range(0, 7), 3'($urandom_range(0, 7)), 4'(i));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain(1);

        send_ref(2, 64'h8000000000000000, 63, MODE_SRA, 4'd1);
        send_ref(2, 64'h0123456789ABCDEF, 36, MODE_ROL, 4'd2);
        fork
            begin
                repeat (50) begin
                    ordy[2] = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                end
                ordy[2] = 1'b1;
            end
            for (int i = 0; i < 20; i++) begin
                send_ref(2, rand_data(64), $urandom_range(0, 63), 3'($urandom_range(0, 7)), 4'(i));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        join
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
